// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory. Stores are sized,
// aligned and lane-replicated on entry, queued in FIFO order, and written
// out one per cycle from the oldest entry. Loads that hit a resident word
// are flagged so the pipeline can stall. A flush blocks new stores until
// the queue has drained.
module store_buffer #(
    parameter int NBITS  = 32,
    parameter int TNBITS = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_StoreValid,
    input  logic [NBITS-1:0]           i_Addr,
    input  logic [NBITS-1:0]           i_Dato,
    input  logic [TNBITS-1:0]          i_Tamano,
    output logic                       o_StoreReady,
    input  logic                       i_LoadValid,
    input  logic [NBITS-1:0]           i_LoadAddr,
    output logic                       o_LoadHazard,
    input  logic                       i_Flush,
    output logic                       o_FlushDone,
    output logic                       o_MemWrite,
    input  logic                       i_MemReady,
    output logic [NBITS-1:0]           o_MemAddr,
    output logic [NBITS-1:0]           o_MemDato,
    output logic [NBITS/8-1:0]         o_MemByteEn,
    output logic [$clog2(DEPTH):0]     o_Count,
    output logic                       o_Error
);
    localparam int BW = NBITS / 8;
    // DEPTH is a power of two (>= 2), so pointers wrap by natural overflow
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [TNBITS-1:0] SZ_SW = TNBITS'(0);
    localparam logic [TNBITS-1:0] SZ_SB = TNBITS'(1);
    localparam logic [TNBITS-1:0] SZ_SH = TNBITS'(2);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    typedef struct packed {
        logic [NBITS-1:0] addr;
        logic [NBITS-1:0] data;
        logic [BW-1:0]    be;
    } entry_t;

    state_t           state, state_nxt;
    entry_t           entries [DEPTH];
    entry_t           new_entry;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic             legal, push, pop, hit;
    logic             error_q, flush_done_q, flush_done_nxt;

    // Size/alignment check and formatting of the incoming store
    always_comb begin
        legal          = 1'b0;
        new_entry      = '0;
        new_entry.addr = {i_Addr[NBITS-1:2], 2'b00};
        case (i_Tamano)
            SZ_SW: begin
                legal          = (i_Addr[1:0] == 2'b00);
                new_entry.be   = '1;
                new_entry.data = i_Dato;
            end
            SZ_SH: begin
                legal          = (i_Addr[0] == 1'b0);
                new_entry.be   = BW'(4'b0011) << i_Addr[1:0];
                new_entry.data = {(NBITS/16){i_Dato[15:0]}};
            end
            SZ_SB: begin
                legal          = 1'b1;
                new_entry.be   = BW'(4'b0001) << i_Addr[1:0];
                new_entry.data = {(NBITS/8){i_Dato[7:0]}};
            end
            default: legal = 1'b0;
        endcase
    end

    // Readiness uses the cycle-start count, so a full buffer refuses a push
    // even when the head pops in the same cycle
    assign o_StoreReady = (count < FULL) && (state != FLUSH);
    assign push         = i_StoreValid && o_StoreReady && legal;
    assign o_MemWrite   = (count != '0);
    assign pop          = o_MemWrite && i_MemReady;
    assign count_nxt    = count + CW'(push) - CW'(pop);

    // Head entry drives memory; zero when nothing is queued
    assign o_MemAddr   = o_MemWrite ? entries[rd_ptr].addr : '0;
    assign o_MemDato   = o_MemWrite ? entries[rd_ptr].data : '0;
    assign o_MemByteEn = o_MemWrite ? entries[rd_ptr].be   : '0;
    assign o_Count     = count;
    assign o_Error     = error_q;
    assign o_FlushDone = flush_done_q;

    // Word-address match against every resident entry (popping one included)
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr[NBITS-1:2] == i_LoadAddr[NBITS-1:2]))
                hit = 1'b1;
        end
    end

    assign o_LoadHazard = i_LoadValid && hit;

    // Next state; a flush on an already-empty buffer completes immediately
    always_comb begin
        state_nxt      = state;
        flush_done_nxt = 1'b0;
        case (state)
            IDLE:    if (push) state_nxt = DRAIN;
            DRAIN:   if (count_nxt == '0) state_nxt = IDLE;
            default: state_nxt = FLUSH;
        endcase
        if (i_Flush || state == FLUSH) begin
            if (count_nxt == '0) begin
                state_nxt      = IDLE;
                flush_done_nxt = 1'b1;
            end else begin
                state_nxt = FLUSH;
            end
        end
    end

    // Control state: pointers, occupancy, FSM and one-cycle pulses
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            valid        <= '0;
            error_q      <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            error_q      <= i_StoreValid && o_StoreReady && !legal;
            flush_done_q <= flush_done_nxt;
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
        end
    end

    // Entry payload storage; occupancy is tracked by valid/count, so no reset
    always_ff @(posedge i_clk) begin
        if (push) entries[wr_ptr] <= new_entry;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The module SHALL have parameter NBITS, default 32, meaning data and address width.
REQ-002 The module SHALL have parameter TNBITS, default 2, meaning store-size code width (00 SW, 01 SB, 10 SH, 11 invalid).
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning number of buffer entries (power of two).
REQ-004 The module SHALL have the following ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_StoreValid  in  1  MEM stage presents a store this cycle.
- i_Addr  in  NBITS  store byte address.
- i_Dato  in  NBITS  store data, right-justified.
- i_Tamano  in  TNBITS  store size code.
- o_StoreReady  out  1  buffer can accept a store this cycle.
- i_LoadValid  in  1  MEM stage presents a load this cycle.
- i_LoadAddr  in  NBITS  load byte address.
- o_LoadHazard  out  1  load word matches a resident entry; pipeline must stall.
- i_Flush  in  1  request to drain and block new stores.
- o_FlushDone  out  1  one-cycle pulse when a flush completes.
- o_MemWrite  out  1  write request to data memory.
- i_MemReady  in  1  data memory accepts the write this cycle.
- o_MemAddr  out  NBITS  word-aligned write address.
- o_MemDato  out  NBITS  lane-replicated write data.
- o_MemByteEn  out  NBITS/8  byte-lane enables.
- o_Count  out  log2(DEPTH)+1  number of valid entries.
- o_Error  out  1  one-cycle pulse: store rejected.

Function
REQ-005 The block SHALL accept a store (push) when i_StoreValid && o_StoreReady && the store is legal; o_StoreReady = (o_Count < DEPTH) && state != FLUSH.
REQ-006 Legal stores SHALL be: SW with i_Addr[1:0]=00; SH with i_Addr[0]=0; SB at any address.
REQ-007 An illegal store (size 11 or misaligned) presented while o_StoreReady=1 SHALL NOT be enqueued and SHALL raise o_Error for exactly the next cycle.
REQ-008 An entry SHALL store {i_Addr[NBITS-1:2],2'b00}, the byte enables and the data.
REQ-009 The byte enables SHALL be: SW 1111; SH 0011<<i_Addr[1:0]; SB 0001<<i_Addr[1:0].
REQ-010 The stored data SHALL be: SW i_Dato; SH {2{i_Dato[15:0]}}; SB {4{i_Dato[7:0]}}.
REQ-011 o_MemWrite SHALL equal (o_Count != 0), with o_MemAddr/o_MemDato/o_MemByteEn driven from the head (oldest) entry, all from registers.
REQ-012 A pop SHALL occur on each cycle with o_MemWrite && i_MemReady; back-to-back pops SHALL be supported.
REQ-013 Write outputs SHALL hold stable while o_MemWrite=1 and i_MemReady=0.
REQ-014 Push-to-o_MemWrite latency SHALL be one cycle; there is no same-cycle bypass.
REQ-015 Simultaneous push and pop SHALL leave o_Count unchanged; when o_Count=DEPTH, a push in the same cycle as a pop SHALL be refused, because o_StoreReady is evaluated from the cycle-start count.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH, and entries SHALL drain in strict FIFO order.
REQ-017 o_LoadHazard SHALL be combinational: i_LoadValid && (some valid entry has a word address equal to i_LoadAddr[NBITS-1:2]); an entry popped in the current cycle still counts.
REQ-018 The state machine SHALL have states IDLE (count 0), DRAIN (count>0) and FLUSH.
REQ-019 State transitions SHALL be: IDLE->DRAIN on push; DRAIN->IDLE when the last entry pops with no push; any state->FLUSH on i_Flush; FLUSH->IDLE when the count reaches 0.
REQ-020 On reaching the count of 0 from FLUSH, o_FlushDone SHALL pulse for one cycle.
REQ-021 i_Flush asserted while already empty SHALL produce o_FlushDone on the next cycle.
REQ-022 Pushes SHALL be blocked in FLUSH, while pops continue.

Reset
REQ-023 When i_reset=0 at a clock edge, all outputs SHALL be driven to the following values from the next cycle: o_Count=0, o_MemWrite=0, o_MemAddr=0, o_MemDato=0, o_MemByteEn=0, o_Error=0, o_FlushDone=0, o_StoreReady=1, state=IDLE, pointers=0.
REQ-024 A reset asserted mid-drain SHALL discard all entries without completing the pending write.

Verification
REQ-025 The bench SHALL cover SB: i_Addr=0x103, i_Dato=0xAABBCCDD, i_Tamano=01, i_MemReady=1 -> next cycle o_MemWrite=1, o_MemAddr=0x100, o_MemByteEn=1000, o_MemDato=0xDDDDDDDD.
REQ-026 The bench SHALL cover SH: i_Addr=0x202, i_Dato=0x1234, i_Tamano=10 -> o_MemByteEn=1100, o_MemDato=0x12341234; i_Addr=0x201 -> o_Error pulse, o_Count stays 0.
REQ-027 The bench SHALL cover fill: 4 SW stores with i_MemReady=0 -> o_Count=4, o_StoreReady=0; then i_MemReady=1 -> 4 writes in order on 4 consecutive cycles.
REQ-028 The bench SHALL cover a hazard: SW to 0x40 buffered, i_MemReady=0, load to 0x42 -> o_LoadHazard=1; after the pop -> 0.
REQ-029 The bench SHALL cover flush: 2 entries plus i_Flush, with an SB offered during the flush -> SB refused, o_FlushDone pulses on the cycle after the second pop.
REQ-030 The bench SHALL cover reset mid-drain: 3 entries, i_reset=0 for one cycle -> o_Count=0, o_MemWrite=0 next cycle.
